// File: rtl/control_register_bank_pkg.sv
// Shared definitions for the control register bank.
// Software op encoding applied to shadow registers.
package control_register_bank_pkg;

    localparam int CR_OP_W = 2;

    typedef enum logic [CR_OP_W-1:0] {
        CR_OP_WRITE  = 2'd0,
        CR_OP_SET    = 2'd1,
        CR_OP_CLEAR  = 2'd2,
        CR_OP_TOGGLE = 2'd3
    } cr_op_e;

endpackage

// File: rtl/control_register_bank_cell.sv
// One shadow/active register pair with op decode,
// sticky hardware set and change detection.
import control_register_bank_pkg::*;

module control_register_cell #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             wr_en,
    input  cr_op_e           wr_op,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit,
    input  logic [WIDTH-1:0] hw_set,
    output logic [WIDTH-1:0] shadow,
    output logic [WIDTH-1:0] active,
    output logic             changed
);

    logic [WIDTH-1:0] sw_val;
    logic [WIDTH-1:0] shadow_n;
    logic [WIDTH-1:0] active_n;

    always_comb begin
        sw_val = shadow;
        if (wr_en) begin
            unique case (wr_op)
                CR_OP_WRITE:  sw_val = wr_data;
                CR_OP_SET:    sw_val = shadow | wr_data;
                CR_OP_CLEAR:  sw_val = shadow & ~wr_data;
                CR_OP_TOGGLE: sw_val = shadow ^ wr_data;
            endcase
        end
    end

    // Hardware set is applied last so it beats any same-cycle clear.
    assign shadow_n = sw_val | hw_set;
    assign active_n = (commit ? shadow : active) | hw_set;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            shadow  <= RESET_VAL;
            active  <= RESET_VAL;
            changed <= 1'b0;
        end else begin
            shadow  <= shadow_n;
            active  <= active_n;
            changed <= (active_n != active);
        end
    end

endmodule

// File: rtl/control_register_bank.sv
// Bank of shadow/active control registers with commit,
// sticky hardware set, registered read port and error flag.
import control_register_bank_pkg::*;

module control_register_bank #(
    parameter int               WIDTH     = 16,
    parameter int               NUM_REGS  = 4,
    parameter int               ADDR_W    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      iWrEn,
    input  logic [ADDR_W-1:0]         iWrAddr,
    input  logic [CR_OP_W-1:0]        iWrOp,
    input  logic [WIDTH-1:0]          iWrData,
    input  logic                      iCommit,
    input  logic [NUM_REGS*WIDTH-1:0] iHwSet,
    input  logic                      iRdEn,
    input  logic [ADDR_W-1:0]         iRdAddr,
    input  logic                      iRdShadow,
    output logic [WIDTH-1:0]          oRdData,
    output logic                      oRdValid,
    output logic                      oWrError,
    output logic [NUM_REGS-1:0]       oChanged,
    output logic [NUM_REGS*WIDTH-1:0] oControlRegister
);

    // One extra bit so NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] NREGS = NUM_REGS[ADDR_W:0];

    logic             wr_in;
    logic             rd_in;
    logic             wr_ok;
    logic             wr_bad;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] shadow_w [NUM_REGS];
    logic [WIDTH-1:0] active_w [NUM_REGS];

    assign wr_in  = {1'b0, iWrAddr} < NREGS;
    assign rd_in  = {1'b0, iRdAddr} < NREGS;
    assign wr_ok  = iWrEn && wr_in;
    assign wr_bad = iWrEn && !wr_in;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        control_register_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .Clock   (Clock),
            .Reset   (Reset),
            .wr_en   (wr_ok && (iWrAddr == ADDR_W'(i))),
            .wr_op   (cr_op_e'(iWrOp)),
            .wr_data (iWrData),
            .commit  (iCommit),
            .hw_set  (iHwSet[i*WIDTH +: WIDTH]),
            .shadow  (shadow_w[i]),
            .active  (active_w[i]),
            .changed (oChanged[i])
        );

        assign oControlRegister[i*WIDTH +: WIDTH] = active_w[i];
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_in && (iRdAddr == ADDR_W'(i))) begin
                rd_word = iRdShadow ? shadow_w[i] : active_w[i];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oRdData  <= '0;
            oRdValid <= 1'b0;
            oWrError <= 1'b0;
        end else begin
            oRdValid <= iRdEn;
            oWrError <= wr_bad;
            if (iRdEn) begin
                oRdData <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_control_register_bank.sv
// Scoreboard bench for control_register_bank: directed
// scenarios plus random ops against an abstract model.
module tb_control_register_bank;

    localparam int W = 16;
    localparam int N = 3;
    localparam int A = 2;

    logic           Clock = 1'b0;
    logic           Reset = 1'b0;
    logic           iWrEn = 1'b0;
    logic [A-1:0]   iWrAddr = '0;
    logic [1:0]     iWrOp = '0;
    logic [W-1:0]   iWrData = '0;
    logic           iCommit = 1'b0;
    logic [N*W-1:0] iHwSet = '0;
    logic           iRdEn = 1'b0;
    logic [A-1:0]   iRdAddr = '0;
    logic           iRdShadow = 1'b0;
    logic [W-1:0]   oRdData;
    logic           oRdValid;
    logic           oWrError;
    logic [N-1:0]   oChanged;
    logic [N*W-1:0] oControlRegister;

    control_register_bank #(
        .WIDTH     (W),
        .NUM_REGS  (N),
        .ADDR_W    (A),
        .RESET_VAL (16'h0000)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .iWrEn            (iWrEn),
        .iWrAddr          (iWrAddr),
        .iWrOp            (iWrOp),
        .iWrData          (iWrData),
        .iCommit          (iCommit),
        .iHwSet           (iHwSet),
        .iRdEn            (iRdEn),
        .iRdAddr          (iRdAddr),
        .iRdShadow        (iRdShadow),
        .oRdData          (oRdData),
        .oRdValid         (oRdValid),
        .oWrError         (oWrError),
        .oChanged         (oChanged),
        .oControlRegister (oControlRegister)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit             rv;
        bit             err;
        logic [N-1:0]   chg;
        logic [N*W-1:0] ctrl;
    } exp_t;

    exp_t         cyc_q[$];
    logic [W-1:0] rd_q[$];
    logic [W-1:0] sh [N];
    logic [W-1:0] ac [N];
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] apply(input int op,
                                           input logic [W-1:0] s,
                                           input logic [W-1:0] d);
        case (op)
            0: return d;
            1: return s | d;
            2: return s & ~d;
            default: return s ^ d;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh[i] = '0;
            ac[i] = '0;
        end
    endtask

    task automatic idle();
        iWrEn = 0; iWrAddr = '0; iWrOp = '0; iWrData = '0;
        iCommit = 0; iHwSet = '0;
        iRdEn = 0; iRdAddr = '0; iRdShadow = 0;
    endtask

    task automatic step(input bit we, input int wa, input int op,
                        input logic [W-1:0] wd, input bit cm,
                        input logic [N*W-1:0] hw, input bit re,
                        input int ra, input bit rs);
        exp_t         e;
        logic [W-1:0] sh_n [N];
        logic [W-1:0] ac_n [N];
        @(negedge Clock);
        iWrEn = we; iWrAddr = wa[A-1:0]; iWrOp = op[1:0];
        iWrData = wd; iCommit = cm; iHwSet = hw;
        iRdEn = re; iRdAddr = ra[A-1:0]; iRdShadow = rs;
        if (re) rd_q.push_back(ra < N ? (rs ? sh[ra] : ac[ra]) : '0);
        e.rv  = re;
        e.err = we && (wa >= N);
        for (int i = 0; i < N; i++) begin
            sh_n[i] = sh[i];
            if (we && wa == i) sh_n[i] = apply(op, sh[i], wd);
            sh_n[i] |= hw[i*W +: W];
            ac_n[i] = (cm ? sh[i] : ac[i]) | hw[i*W +: W];
            e.chg[i] = (ac_n[i] != ac[i]);
            e.ctrl[i*W +: W] = ac_n[i];
        end
        for (int i = 0; i < N; i++) begin
            sh[i] = sh_n[i];
            ac[i] = ac_n[i];
        end
        cyc_q.push_back(e);
        @(posedge Clock);
        #1;
        idle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("rd_valid", 64'(oRdValid), 64'(e.rv));
                chk("wr_error", 64'(oWrError), 64'(e.err));
                chk("changed", 64'(oChanged), 64'(e.chg));
                chk("ctrl", 64'(oControlRegister), 64'(e.ctrl));
                if (e.rv && oRdValid) begin
                    if (rd_q.size() == 0) begin
                        chk("rd_queue", 64'd0, 64'd1);
                    end else begin
                        chk("rd_data", 64'(oRdData), 64'(rd_q.pop_front()));
                    end
                end
            end else if (oRdValid || oWrError || |oChanged) begin
                chk("unexpected_pulse",
                    64'({oRdValid, oWrError, oChanged}), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [N*W-1:0] hw;
        idle();
        model_reset();
        #12;
        chk("reset_ctrl", 64'(oControlRegister), 64'd0);
        chk("reset_outs", 64'({oRdValid, oWrError, oChanged, oRdData}), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;

        // Shadow ops then commit on reg 1
        step(1, 1, 0, 16'h00F0, 0, '0, 0, 0, 0);
        step(1, 1, 1, 16'h0F00, 0, '0, 0, 0, 0);
        step(1, 1, 2, 16'h0010, 0, '0, 0, 0, 0);
        step(1, 1, 3, 16'hFFFF, 0, '0, 1, 1, 1);
        chk("t2_active_pre", 64'(oControlRegister[31:16]), 64'h0);
        step(0, 0, 0, '0, 0, '0, 1, 1, 1);
        chk("t2_shadow_rd", 64'(oRdData), 64'hF01F);
        step(0, 0, 0, '0, 1, '0, 0, 0, 0);
        chk("t2_active", 64'(oControlRegister[31:16]), 64'hF01F);
        chk("t2_changed", 64'(oChanged), 64'b010);
        step(0, 0, 0, '0, 1, '0, 0, 0, 0);
        chk("t2_no_repulse", 64'(oChanged), 64'b000);

        // Commit and write colliding on reg 2
        step(1, 2, 0, 16'h1234, 0, '0, 0, 0, 0);
        step(1, 2, 0, 16'hABCD, 1, '0, 0, 0, 0);
        chk("t3_active", 64'(oControlRegister[47:32]), 64'h1234);
        step(0, 0, 0, '0, 0, '0, 1, 2, 1);
        chk("t3_shadow", 64'(oRdData), 64'hABCD);

        // Sticky hardware set beats clear and commit
        step(1, 0, 0, 16'h0000, 1, '0, 0, 0, 0);
        hw = '0;
        hw[3] = 1'b1;
        step(1, 0, 2, 16'h0008, 1, hw, 0, 0, 0);
        chk("t4_active", 64'(oControlRegister[15:0]), 64'h0008);
        step(0, 0, 0, '0, 0, '0, 1, 0, 1);
        chk("t4_shadow", 64'(oRdData), 64'h0008);

        // Out-of-range write and read
        step(1, 3, 0, 16'hFFFF, 0, '0, 0, 0, 0);
        chk("t5_err", 64'(oWrError), 64'd1);
        step(0, 0, 0, '0, 0, '0, 1, 3, 0);
        chk("t5_rd_oob", 64'({oRdValid, oRdData}), 64'h10000);
        chk("t5_err_clear", 64'(oWrError), 64'd0);

        for (int c = 0; c < 300; c++) begin
            hw = '0;
            if ($urandom_range(7, 0) == 0) hw[$urandom_range(N*W-1, 0)] = 1'b1;
            step($urandom_range(1, 0), $urandom_range(3, 0),
                 $urandom_range(3, 0), W'($urandom),
                 $urandom_range(3, 0) == 0, hw,
                 $urandom_range(1, 0), $urandom_range(3, 0),
                 $urandom_range(1, 0));
        end

        // Reset asserted between edges during back-to-back writes
        for (int k = 0; k < 4; k++)
            step(1, k % N, 0, W'($urandom), 1, '0, 1, k % N, 0);
        @(negedge Clock);
        iWrEn = 1; iWrAddr = 2'd1; iWrOp = 2'd0; iWrData = 16'h5A5A;
        iCommit = 1; iRdEn = 1;
        #2;
        Reset = 1'b0;
        #1;
        chk("t6_ctrl", 64'(oControlRegister), 64'd0);
        chk("t6_outs", 64'({oRdValid, oWrError, oChanged, oRdData}), 64'd0);
        model_reset();
        @(negedge Clock);
        idle();
        @(negedge Clock);
        Reset = 1'b1;
        step(0, 0, 0, '0, 0, '0, 0, 0, 0);
        step(0, 0, 0, '0, 0, '0, 1, 1, 1);
        chk("t6_shadow_rd", 64'(oRdData), 64'h0);
        for (int c = 0; c < 40; c++)
            step(1, $urandom_range(2, 0), $urandom_range(3, 0),
                 W'($urandom), $urandom_range(1, 0), '0, 1,
                 $urandom_range(3, 0), $urandom_range(1, 0));

        repeat (3) @(negedge Clock);
        chk("queues_drained", 64'(cyc_q.size() + rd_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
